// File: rtl/stage_writeback.sv
// Purpose: RISC-V W stage; registers M results, extracts load data, drives regfile/CSR writes.
// Latency: 1 cycle from M capture to W outputs; slow loads wait in WAIT up to LOAD_TIMEOUT cycles.
// Backpressure: stallM (combinational) freezes M and upstream while a load response is outstanding.
module stage_writeback #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             validM,
    input  logic [1:0]       regSrcM,
    input  logic             regWriteM,
    input  logic             csrWriteM,
    input  logic [11:0]      csrAddrM,
    input  logic [31:0]      aluResultM,
    input  logic [31:0]      pcPlus4M,
    input  logic [31:0]      csrResultM,
    input  logic [31:0]      csrRdataM,
    input  logic [4:0]       rdAddrM,
    input  logic [2:0]       dmemSizeM,
    input  logic [31:0]      dmemRdata,
    input  logic             dmemRvalid,
    output logic             stallM,
    output logic             regWriteW,
    output logic [4:0]       rdAddrW,
    output logic [31:0]      rdDataW,
    output logic             csrWriteW,
    output logic [11:0]      csrAddrW,
    output logic [31:0]      csrWdataW,
    output logic             loadTimeout,
    output logic [CNT_W-1:0] instRetired
);

    localparam int TW = $clog2(LOAD_TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(LOAD_TIMEOUT - 1);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             valid_w_q, valid_w_d;
    logic [1:0]       reg_src_q, reg_src_d;
    logic             reg_write_q, reg_write_d;
    logic             csr_write_q, csr_write_d;
    logic [11:0]      csr_addr_q, csr_addr_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      csr_res_q, csr_res_d;
    logic [31:0]      csr_rdata_q, csr_rdata_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [2:0]       size_q, size_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        load_m;
    logic        capture;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign load_m = validM & (regSrcM == 2'b01);

    // Next-state, stall and capture decision for the RUN/WAIT load handshake.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        capture   = 1'b0;
        stallM    = 1'b0;
        case (state_q)
            S_RUN: begin
                if (load_m && !dmemRvalid) begin
                    stallM  = 1'b1;
                    state_d = S_WAIT;
                    timer_d = '0;
                end else begin
                    capture = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmemRvalid) begin
                    capture = 1'b1;
                    state_d = S_RUN;
                    timer_d = '0;
                end else if (timer_q == TMAX) begin
                    // Give up: the load leaves M as a bubble and the event is latched.
                    timeout_d = 1'b1;
                    state_d   = S_RUN;
                    timer_d   = '0;
                end else begin
                    stallM  = 1'b1;
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // W pipeline register inputs: take M fields on capture, otherwise hold and inject a bubble.
    always_comb begin
        valid_w_d   = capture & validM;
        reg_src_d   = reg_src_q;
        reg_write_d = reg_write_q;
        csr_write_d = csr_write_q;
        csr_addr_d  = csr_addr_q;
        alu_d       = alu_q;
        pc4_d       = pc4_q;
        csr_res_d   = csr_res_q;
        csr_rdata_d = csr_rdata_q;
        rd_addr_d   = rd_addr_q;
        size_d      = size_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, valid_w_q};
        if (capture) begin
            reg_src_d   = regSrcM;
            reg_write_d = regWriteM;
            csr_write_d = csrWriteM;
            csr_addr_d  = csrAddrM;
            alu_d       = aluResultM;
            pc4_d       = pcPlus4M;
            csr_res_d   = csrResultM;
            csr_rdata_d = csrRdataM;
            rd_addr_d   = rdAddrM;
            size_d      = dmemSizeM;
            rdata_d     = dmemRdata;
        end
    end

    // Load data extraction from the registered word; misaligned low offset bits are ignored.
    always_comb begin
        case (alu_q[1:0])
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    // Write-back value select.
    always_comb begin
        case (reg_src_q)
            2'b00:   rdDataW = alu_q;
            2'b01:   rdDataW = ld_data;
            2'b10:   rdDataW = pc4_q;
            default: rdDataW = csr_rdata_q;
        endcase
    end

    assign regWriteW   = valid_w_q & reg_write_q & (rd_addr_q != 5'd0);
    assign rdAddrW     = rd_addr_q;
    assign csrWriteW   = valid_w_q & csr_write_q;
    assign csrAddrW    = csr_addr_q;
    assign csrWdataW   = csr_res_q;
    assign loadTimeout = timeout_q;
    assign instRetired = cnt_q;

    // State and W registers; synchronous reset aborts any pending load.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q     <= S_RUN;
            timer_q     <= '0;
            valid_w_q   <= 1'b0;
            reg_src_q   <= 2'b00;
            reg_write_q <= 1'b0;
            csr_write_q <= 1'b0;
            csr_addr_q  <= 12'h0;
            alu_q       <= 32'h0;
            pc4_q       <= 32'h0;
            csr_res_q   <= 32'h0;
            csr_rdata_q <= 32'h0;
            rd_addr_q   <= 5'd0;
            size_q      <= 3'b000;
            rdata_q     <= 32'h0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            valid_w_q   <= valid_w_d;
            reg_src_q   <= reg_src_d;
            reg_write_q <= reg_write_d;
            csr_write_q <= csr_write_d;
            csr_addr_q  <= csr_addr_d;
            alu_q       <= alu_d;
            pc4_q       <= pc4_d;
            csr_res_q   <= csr_res_d;
            csr_rdata_q <= csr_rdata_d;
            rd_addr_q   <= rd_addr_d;
            size_q      <= size_d;
            rdata_q     <= rdata_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_stage_writeback.sv
module tb_stage_writeback;

    localparam int LT = 8;

    logic        clk = 1'b0;
    logic        rstN;
    logic        validM;
    logic [1:0]  regSrcM;
    logic        regWriteM;
    logic        csrWriteM;
    logic [11:0] csrAddrM;
    logic [31:0] aluResultM;
    logic [31:0] pcPlus4M;
    logic [31:0] csrResultM;
    logic [31:0] csrRdataM;
    logic [4:0]  rdAddrM;
    logic [2:0]  dmemSizeM;
    logic [31:0] dmemRdata;
    logic        dmemRvalid;
    logic        stallM;
    logic        regWriteW;
    logic [4:0]  rdAddrW;
    logic [31:0] rdDataW;
    logic        csrWriteW;
    logic [11:0] csrAddrW;
    logic [31:0] csrWdataW;
    logic        loadTimeout;
    logic [63:0] instRetired;

    stage_writeback #(.LOAD_TIMEOUT(LT), .CNT_W(64)) dut (
        .clk(clk), .rstN(rstN), .validM(validM), .regSrcM(regSrcM),
        .regWriteM(regWriteM), .csrWriteM(csrWriteM), .csrAddrM(csrAddrM),
        .aluResultM(aluResultM), .pcPlus4M(pcPlus4M), .csrResultM(csrResultM),
        .csrRdataM(csrRdataM), .rdAddrM(rdAddrM), .dmemSizeM(dmemSizeM),
        .dmemRdata(dmemRdata), .dmemRvalid(dmemRvalid), .stallM(stallM),
        .regWriteW(regWriteW), .rdAddrW(rdAddrW), .rdDataW(rdDataW),
        .csrWriteW(csrWriteW), .csrAddrW(csrAddrW), .csrWdataW(csrWdataW),
        .loadTimeout(loadTimeout), .instRetired(instRetired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [1:0]  src;
        logic        rw;
        logic        cw;
        logic [11:0] caddr;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] cres;
        logic [31:0] crd;
        logic [4:0]  rd;
        logic [2:0]  size;
        logic [31:0] rdata;
        logic        e_rw;
        logic        e_cw;
        logic [31:0] e_data;
        logic        chk_data;
    } vec_t;

    int     n_pass = 0;
    int     n_total = 0;
    longint exp_cnt = 0;
    vec_t   vecs[12];

    function automatic vec_t mk(logic vld, logic [1:0] src, logic rw, logic cw, logic [11:0] caddr,
                                logic [31:0] alu, logic [31:0] pc4, logic [31:0] cres, logic [31:0] crd,
                                logic [4:0] rd, logic [2:0] size, logic [31:0] rdata,
                                logic e_rw, logic e_cw, logic [31:0] e_data, logic chk_data);
        vec_t v;
        v.vld = vld; v.src = src; v.rw = rw; v.cw = cw; v.caddr = caddr; v.alu = alu;
        v.pc4 = pc4; v.cres = cres; v.crd = crd; v.rd = rd; v.size = size; v.rdata = rdata;
        v.e_rw = e_rw; v.e_cw = e_cw; v.e_data = e_data; v.chk_data = chk_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bubble();
        validM = 1'b0; regSrcM = 2'b00; regWriteM = 1'b0; csrWriteM = 1'b0;
        csrAddrM = 12'h0; aluResultM = 32'h0; pcPlus4M = 32'h0; csrResultM = 32'h0;
        csrRdataM = 32'h0; rdAddrM = 5'd0; dmemSizeM = 3'b000; dmemRdata = 32'h0;
        dmemRvalid = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        validM = v.vld; regSrcM = v.src; regWriteM = v.rw; csrWriteM = v.cw;
        csrAddrM = v.caddr; aluResultM = v.alu; pcPlus4M = v.pc4; csrResultM = v.cres;
        csrRdataM = v.crd; rdAddrM = v.rd; dmemSizeM = v.size; dmemRdata = v.rdata;
        dmemRvalid = 1'b1;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [31:0] rdata);
        drive_bubble();
        validM = 1'b1; regSrcM = 2'b01; regWriteM = 1'b1; rdAddrM = rd;
        dmemSizeM = 3'b010; dmemRdata = rdata; dmemRvalid = 1'b0;
    endtask

    initial begin
        int writes;
        int stalls;

        vecs[0]  = mk(1, 2'b00, 1, 0, 12'h0,   32'h0000_1234, 32'h0, 32'h0,  32'h0,    5'd5, 3'b000, 32'h0,         1, 0, 32'h0000_1234, 1);
        vecs[1]  = mk(1, 2'b01, 1, 0, 12'h0,   32'h0000_0003, 32'h0, 32'h0,  32'h0,    5'd6, 3'b000, 32'h80FF_1234, 1, 0, 32'hFFFF_FF80, 1);
        vecs[2]  = mk(1, 2'b01, 1, 0, 12'h0,   32'h0000_0002, 32'h0, 32'h0,  32'h0,    5'd6, 3'b101, 32'h80FF_1234, 1, 0, 32'h0000_80FF, 1);
        vecs[3]  = mk(1, 2'b01, 1, 0, 12'h0,   32'h0000_0002, 32'h0, 32'h0,  32'h0,    5'd7, 3'b001, 32'h80FF_1234, 1, 0, 32'hFFFF_80FF, 1);
        vecs[4]  = mk(1, 2'b01, 1, 0, 12'h0,   32'h0000_0002, 32'h0, 32'h0,  32'h0,    5'd8, 3'b100, 32'h80FF_1234, 1, 0, 32'h0000_00FF, 1);
        vecs[5]  = mk(1, 2'b01, 1, 0, 12'h0,   32'h0000_1000, 32'h0, 32'h0,  32'h0,    5'd9, 3'b000, 32'h80FF_1234, 1, 0, 32'h0000_0034, 1);
        vecs[6]  = mk(1, 2'b01, 1, 0, 12'h0,   32'h0000_0000, 32'h0, 32'h0,  32'h0,    5'd9, 3'b010, 32'h80FF_1234, 1, 0, 32'h80FF_1234, 1);
        vecs[7]  = mk(1, 2'b01, 1, 0, 12'h0,   32'h0000_0001, 32'h0, 32'h0,  32'h0,    5'd9, 3'b101, 32'h80FF_1234, 1, 0, 32'h0000_1234, 1);
        vecs[8]  = mk(1, 2'b10, 1, 0, 12'h0,   32'h5555_0000, 32'h0000_0104, 32'h0, 32'h0, 5'd1, 3'b000, 32'h0, 1, 0, 32'h0000_0104, 1);
        vecs[9]  = mk(1, 2'b11, 1, 1, 12'h300, 32'h0,         32'h0, 32'h88, 32'hDEAD, 5'd3, 3'b000, 32'h0,         1, 1, 32'h0000_DEAD, 1);
        vecs[10] = mk(1, 2'b00, 1, 0, 12'h0,   32'h0000_0777, 32'h0, 32'h0,  32'h0,    5'd0, 3'b000, 32'h0,         0, 0, 32'h0000_0777, 1);
        vecs[11] = mk(0, 2'b00, 1, 1, 12'h300, 32'h0000_0999, 32'h0, 32'h0,  32'h0,    5'd4, 3'b000, 32'h0,         0, 0, 32'h0,         0);

        // Reset state
        rstN = 1'b0;
        drive_bubble();
        tick();
        tick();
        chk("rst_regWriteW", regWriteW, 0);
        chk("rst_rdDataW", rdDataW, 0);
        chk("rst_csrWriteW", csrWriteW, 0);
        chk("rst_loadTimeout", loadTimeout, 0);
        chk("rst_instRetired", instRetired, 0);
        chk("rst_stallM", stallM, 0);
        rstN = 1'b1;

        // Single-cycle table
        for (int i = 0; i < 12; i++) begin
            drive_vec(vecs[i]);
            #1;
            chk($sformatf("v%0d_stallM", i), stallM, 0);
            tick();
            if (vecs[i].vld) exp_cnt++;
            chk($sformatf("v%0d_regWriteW", i), regWriteW, vecs[i].e_rw);
            chk($sformatf("v%0d_csrWriteW", i), csrWriteW, vecs[i].e_cw);
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_rdDataW", i), rdDataW, vecs[i].e_data);
                chk($sformatf("v%0d_rdAddrW", i), rdAddrW, vecs[i].rd);
            end
            if (vecs[i].e_cw) begin
                chk($sformatf("v%0d_csrAddrW", i), csrAddrW, vecs[i].caddr);
                chk($sformatf("v%0d_csrWdataW", i), csrWdataW, vecs[i].cres);
            end
        end
        drive_bubble();
        tick();
        tick();
        chk("table_instRetired", instRetired, exp_cnt);
        chk("table_csr_one_cycle", csrWriteW, 0);

        // Slow load: response three cycles late
        writes = 0;
        stalls = 0;
        drive_load(5'd7, 32'hCAFE_F00D);
        #1;
        for (int c = 0; c < 3; c++) begin
            if (stallM) stalls++;
            tick();
            if (regWriteW) writes++;
        end
        dmemRvalid = 1'b1;
        #1;
        chk("slow_stall_release", stallM, 0);
        tick();
        if (regWriteW) writes++;
        chk("slow_rdDataW", rdDataW, 32'hCAFE_F00D);
        chk("slow_rdAddrW", rdAddrW, 7);
        exp_cnt++;
        drive_bubble();
        for (int c = 0; c < 3; c++) begin
            tick();
            if (regWriteW) writes++;
        end
        chk("slow_stall_cycles", stalls, 3);
        chk("slow_write_count", writes, 1);
        chk("slow_instRetired", instRetired, exp_cnt);

        // Timeout: response never arrives
        writes = 0;
        stalls = 0;
        drive_load(5'd12, 32'h1111_2222);
        #1;
        while (stallM && stalls < 20) begin
            stalls++;
            tick();
            if (regWriteW) writes++;
        end
        chk("to_stall_cycles", stalls, LT);
        chk("to_flag_before", loadTimeout, 0);
        tick();
        drive_bubble();
        if (regWriteW) writes++;
        chk("to_flag_after", loadTimeout, 1);
        tick();
        if (regWriteW) writes++;
        tick();
        chk("to_no_write", writes, 0);
        chk("to_instRetired", instRetired, exp_cnt);

        // Timeout flag stays set across normal traffic
        drive_vec(vecs[0]);
        tick();
        chk("to_sticky_write", regWriteW, 1);
        drive_bubble();
        tick();
        tick();
        chk("to_sticky_flag", loadTimeout, 1);

        // Reset during WAIT aborts the pending load
        drive_load(5'd13, 32'h3333_4444);
        tick();
        tick();
        chk("rw_in_wait_stall", stallM, 1);
        rstN = 1'b0;
        drive_bubble();
        tick();
        chk("rw_regWriteW", regWriteW, 0);
        chk("rw_loadTimeout", loadTimeout, 0);
        chk("rw_instRetired", instRetired, 0);
        chk("rw_rdDataW", rdDataW, 0);
        rstN = 1'b1;
        dmemRvalid = 1'b1;
        #1;
        chk("rw_no_stall", stallM, 0);
        tick();
        chk("rw_no_late_write", regWriteW, 0);
        drive_load(5'd14, 32'h0BAD_BEEF);
        dmemRvalid = 1'b1;
        #1;
        chk("rw_run_no_stall", stallM, 0);
        tick();
        chk("rw_run_write", regWriteW, 1);
        chk("rw_run_data", rdDataW, 32'h0BAD_BEEF);
        drive_bubble();
        tick();
        tick();
        chk("rw_run_instRetired", instRetired, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
